// File: rtl/ats21_pkg.sv
// Shared types and constants for the ATS21 two-requester arbiter.
package ats21_pkg;

  localparam int CTRL_W = 16;
  localparam int DATA_W = 24;
  localparam int STAT_W = 2;

  localparam logic [STAT_W-1:0] STAT_TIMEOUT = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

endpackage

// File: rtl/ats21_rr_arb.sv
// Two-way round-robin pick: with both requests pending, the requester that was
// not granted last wins; a single request is granted directly.
module ats21_rr_arb
  import ats21_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic [1:0] gnt_o
);

  always_comb begin
    gnt_o = 2'b00;
    if (req_i == 2'b11) begin
      gnt_o = last_i ? 2'b01 : 2'b10;
    end else begin
      gnt_o = req_i;
    end
  end

endmodule

// File: rtl/ats21_arbiter.sv
// Arbitrates two requesters onto one ATS21 port: latch the winner's control
// words, issue one strobe, wait for ready or timeout, return the result.
module ats21_arbiter
  import ats21_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              r0_req_i,
  input  logic [CTRL_W-1:0] r0_ctrl_a_i,
  input  logic [CTRL_W-1:0] r0_ctrl_b_i,
  input  logic              r1_req_i,
  input  logic [CTRL_W-1:0] r1_ctrl_a_i,
  input  logic [CTRL_W-1:0] r1_ctrl_b_i,
  output logic              r0_gnt_o,
  output logic              r1_gnt_o,
  output logic              r0_done_o,
  output logic              r1_done_o,
  output logic [DATA_W-1:0] rsp_data_o,
  output logic [STAT_W-1:0] rsp_stat_o,
  output logic              ats_req_o,
  output logic [CTRL_W-1:0] ats_ctrl_a_o,
  output logic [CTRL_W-1:0] ats_ctrl_b_o,
  input  logic              ats_ready_i,
  input  logic [DATA_W-1:0] ats_data_i,
  input  logic [STAT_W-1:0] ats_stat_i,
  output logic              busy_o
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_e            state_q, state_d;
  logic              owner_q, owner_d;
  logic              last_q, last_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CTRL_W-1:0] ctrl_a_q, ctrl_a_d;
  logic [CTRL_W-1:0] ctrl_b_q, ctrl_b_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic [STAT_W-1:0] rsp_stat_q, rsp_stat_d;

  logic [1:0] req_vec;
  logic [1:0] arb_gnt;
  logic [1:0] gnt_vec;
  logic [1:0] done_vec;

  assign req_vec = {r1_req_i, r0_req_i};

  ats21_rr_arb u_rr_arb (
    .req_i  (req_vec),
    .last_i (last_q),
    .gnt_o  (arb_gnt)
  );

  // last_q holds the index granted most recently; resetting it to 1 favours r0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      owner_q    <= 1'b0;
      last_q     <= 1'b1;
      cnt_q      <= '0;
      ctrl_a_q   <= '0;
      ctrl_b_q   <= '0;
      rsp_data_q <= '0;
      rsp_stat_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      last_q     <= last_d;
      cnt_q      <= cnt_d;
      ctrl_a_q   <= ctrl_a_d;
      ctrl_b_q   <= ctrl_b_d;
      rsp_data_q <= rsp_data_d;
      rsp_stat_q <= rsp_stat_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    last_d     = last_q;
    cnt_d      = cnt_q;
    ctrl_a_d   = ctrl_a_q;
    ctrl_b_d   = ctrl_b_q;
    rsp_data_d = rsp_data_q;
    rsp_stat_d = rsp_stat_q;
    case (state_q)
      ST_IDLE: begin
        if (|req_vec) begin
          owner_d  = arb_gnt[1];
          ctrl_a_d = arb_gnt[1] ? r1_ctrl_a_i : r0_ctrl_a_i;
          ctrl_b_d = arb_gnt[1] ? r1_ctrl_b_i : r0_ctrl_b_i;
          state_d  = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        cnt_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // Ready is checked first so a response on the expiry edge is kept.
        if (ats_ready_i) begin
          rsp_data_d = ats_data_i;
          rsp_stat_d = ats_stat_i;
          state_d    = ST_RESP;
        end else if (cnt_q == CNT_LAST) begin
          rsp_data_d = '0;
          rsp_stat_d = STAT_TIMEOUT;
          state_d    = ST_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RESP: begin
        last_d  = owner_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_req_out
    assign gnt_vec[gi]  = (state_q == ST_ISSUE) && (owner_q == 1'(gi));
    assign done_vec[gi] = (state_q == ST_RESP) && (owner_q == 1'(gi));
  end

  assign r0_gnt_o     = gnt_vec[0];
  assign r1_gnt_o     = gnt_vec[1];
  assign r0_done_o    = done_vec[0];
  assign r1_done_o    = done_vec[1];
  assign ats_req_o    = (state_q == ST_ISSUE);
  assign busy_o       = (state_q != ST_IDLE);
  assign ats_ctrl_a_o = ctrl_a_q;
  assign ats_ctrl_b_o = ctrl_b_q;
  assign rsp_data_o   = rsp_data_q;
  assign rsp_stat_o   = rsp_stat_q;

endmodule
